// File: rtl/line_memory_responder_if.sv
// Cache-to-memory line request bus: the cache drives requests (master) and
// the backing memory answers them (slave).
interface line_memory_responder_if #(
   parameter int BLOCK_SIZE = 16
);
   logic                    is_input_valid;
   logic [31:0]             addr;
   logic                    mem_read;
   logic                    mem_write;
   logic [BLOCK_SIZE*8-1:0] din;
   logic                    is_output_valid;
   logic [BLOCK_SIZE*8-1:0] dout;
   logic                    mem_ready;

   modport master (
      output is_input_valid, addr, mem_read, mem_write, din,
      input  is_output_valid, dout, mem_ready
   );

   modport slave (
      input  is_input_valid, addr, mem_read, mem_write, din,
      output is_output_valid, dout, mem_ready
   );
endinterface

// File: rtl/line_memory_responder.sv
// Line-granular backing memory with a fixed DELAY-cycle access time; one
// request in flight at a time, reads answered with a one-cycle valid pulse.
module line_memory_responder #(
   parameter int BLOCK_SIZE = 16,
   parameter int MEM_DEPTH  = 64,
   parameter int DELAY      = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   line_memory_responder_if.slave bus
);
   localparam int LINE_W = BLOCK_SIZE * 8;
   localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W  = $clog2(DELAY + 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [IDX_W-1:0]    idx_q;
   logic [LINE_W-1:0]   wdata_q;
   logic                is_write_q;
   logic                ready_q;
   logic                valid_q;
   logic [LINE_W-1:0]   dout_q;
   logic [LINE_W-1:0]   mem_q [MEM_DEPTH];
   logic                accept_d;
   logic                done_d;
   logic                unused_addr_hi;

   // Upper address bits are deliberately ignored so out-of-range lines wrap.
   assign unused_addr_hi = ^bus.addr[31:IDX_W];

   always_comb begin
      accept_d = 1'b0;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      if (state_q == IDLE) begin
         accept_d = bus.is_input_valid && (bus.mem_read ^ bus.mem_write);
      end else begin
         done_d = (cnt_q == '0);
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         dout_q     <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         cnt_q   <= cnt_d;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  idx_q      <= bus.addr[IDX_W-1:0];
                  wdata_q    <= bus.din;
                  is_write_q <= bus.mem_write;
                  cnt_q      <= CNT_W'(DELAY - 1);
                  ready_q    <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (done_d) begin
                  if (is_write_q) begin
                     mem_q[idx_q] <= wdata_q;
                  end else begin
                     dout_q  <= mem_q[idx_q];
                     valid_q <= 1'b1;
                  end
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_ready       = ready_q;
   assign bus.is_output_valid = valid_q;
   assign bus.dout            = dout_q;
endmodule
